// File: rtl/aes_dec_if.sv
// Job handshake bundle for aes_dec: ciphertext/key in, plaintext out.
interface aes_dec_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;

    // Producer/consumer side (drives jobs, accepts results).
    modport master (
        output in_valid, din, key, out_ready,
        input  in_ready, out_valid, dout
    );

    // Decryption core side.
    modport slave (
        input  in_valid, din, key, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/aes_dec.sv
// Iterative AES-128 inverse cipher, one round per clock, with a one-entry k10 cache.
module aes_dec #(
    parameter int unsigned NR = 10
) (
    input logic       clk,
    input logic       rst_n,
    aes_dec_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StKeyExp, StInit, StRound, StDone} state_e;

    // Forward S-box, byte 0 in the most significant position.
    localparam logic [2047:0] Sbox = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse table derived at elaboration so the two ROMs can never disagree.
    function automatic logic [2047:0] gen_inv_sbox();
        logic [2047:0] t;
        logic [7:0]    i8;
        logic [7:0]    v;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            v  = Sbox[{~i8, 3'b000} +: 8];
            t[{~v, 3'b000} +: 8] = i8;
        end
        return t;
    endfunction

    localparam logic [2047:0] InvSbox = gen_inv_sbox();

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return Sbox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return InvSbox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0]), sub_byte(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Bit position of state byte i (byte 0 is the MSB).
    function automatic logic [6:0] bpos(input logic [3:0] i);
        return {~i, 3'b000};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {9*a, b*a, d*a, e*a} in GF(2^8).
    function automatic logic [31:0] mul_set(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [31:0] m0, m1, m2, m3;
        m0 = mul_set(c[31:24]);
        m1 = mul_set(c[23:16]);
        m2 = mul_set(c[15:8]);
        m3 = mul_set(c[7:0]);
        return {m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24],
                m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8],
                m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16],
                m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0]};
    endfunction

    // InvShiftRows followed by InvSubBytes; byte index is row + 4*column.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        logic [3:0]   dst, src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                dst = 4'(r + 4 * c);
                src = 4'(r + 4 * ((c - r + 4) % 4));
                o[bpos(dst) +: 8] = inv_sub_byte(s[bpos(src) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [1:0]   c2;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            c2 = 2'(c);
            o[{~c2, 5'b00000} +: 32] = inv_mix_col(s[{~c2, 5'b00000} +: 32]);
        end
        return o;
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] b0, b1, b2, b3;
        b0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        b1 = k[95:64] ^ b0;
        b2 = k[63:32] ^ b1;
        b3 = k[31:0] ^ b2;
        return {b0, b1, b2, b3};
    endfunction

    // Recovers k_{i-1} from k_i by undoing the forward recurrence.
    function automatic logic [127:0] rev_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] b0, b1, b2, b3;
        b3 = k[31:0] ^ k[63:32];
        b2 = k[63:32] ^ k[95:64];
        b1 = k[95:64] ^ k[127:96];
        b0 = k[127:96] ^ sub_rot_word(b3) ^ {rc, 24'h0};
        return {b0, b1, b2, b3};
    endfunction

    state_e       state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] wkey_q, wkey_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         cache_valid_q, cache_valid_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_k10_q, cache_k10_d;
    logic [127:0] dout_q, dout_d;
    logic         out_valid_q, out_valid_d;

    logic [7:0]   rc;
    logic [127:0] key_next, key_prev, round_pre, round_res;

    // Both schedules use rcon[rnd+1]: KEYEXP counts up, ROUND counts down.
    assign rc        = rcon(rnd_q + 4'd1);
    assign key_next  = fwd_key(wkey_q, rc);
    assign key_prev  = rev_key(wkey_q, rc);
    assign round_pre = inv_shift_sub(blk_q) ^ key_prev;
    assign round_res = (rnd_q == 4'd0) ? round_pre : inv_mix(round_pre);

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;

    // Next-state and datapath update for the round FSM.
    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        wkey_d        = wkey_q;
        key_d         = key_q;
        rnd_d         = rnd_q;
        cache_valid_d = cache_valid_q;
        cache_key_d   = cache_key_q;
        cache_k10_d   = cache_k10_q;
        dout_d        = dout_q;
        out_valid_d   = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    blk_d  = bus.din;
                    key_d  = bus.key;
                    wkey_d = bus.key;
                    rnd_d  = 4'd0;
                    if (cache_valid_q && (bus.key == cache_key_q)) begin
                        state_d = StInit;
                    end else begin
                        state_d = StKeyExp;
                    end
                end
            end
            StKeyExp: begin
                wkey_d = key_next;
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == 4'(NR - 1)) begin
                    cache_valid_d = 1'b1;
                    cache_key_d   = key_q;
                    cache_k10_d   = key_next;
                    state_d       = StInit;
                end
            end
            StInit: begin
                blk_d   = blk_q ^ cache_k10_q;
                wkey_d  = cache_k10_q;
                rnd_d   = 4'(NR - 1);
                state_d = StRound;
            end
            StRound: begin
                blk_d  = round_res;
                wkey_d = key_prev;
                if (rnd_q == 4'd0) begin
                    dout_d      = round_res;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset; reset also drops the cache.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            blk_q         <= '0;
            wkey_q        <= '0;
            key_q         <= '0;
            rnd_q         <= '0;
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_k10_q   <= '0;
            dout_q        <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            wkey_q        <= wkey_d;
            key_q         <= key_d;
            rnd_q         <= rnd_d;
            cache_valid_q <= cache_valid_d;
            cache_key_q   <= cache_key_d;
            cache_k10_q   <= cache_k10_d;
            dout_q        <= dout_d;
            out_valid_q   <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_aes_dec.sv
// Bench for aes_dec: textbook AES model, cycle-level job/cache timing model, random jobs.
module tb_aes_dec;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    aes_dec_if bus ();

    aes_dec #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    int jobs  = 0;

    logic [7:0] sb [256];
    logic [7:0] isb [256];

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- AES reference model (byte index = row + 4*col) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcv;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rcv = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcv, 24'h0};
                rcv = gmul(rcv, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    function automatic logic [127:0] subb(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127 - 8 * i -: 8] = inv ? isb[s[127 - 8 * i -: 8]] : sb[s[127 - 8 * i -: 8]];
        return o;
    endfunction

    // Row r rotated so that out[r][c] = in[r][c + dir*r].
    function automatic logic [127:0] shift(input logic [127:0] s, input int dir);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + dir * r + 8) % 4)) -: 8];
        return o;
    endfunction

    // Circulant column mix with first row m (bytes m0..m3).
    function automatic logic [127:0] mixcols(input logic [127:0] s, input logic [31:0] m);
        logic [127:0] o;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(m[31 - 8 * ((j - row + 4) % 4) -: 8],
                                     s[127 - 8 * (4 * c + j) -: 8]);
                o[127 - 8 * (4 * c + row) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] c, input logic [127:0] k);
        logic [127:0] s;
        s = c ^ round_key(k, 10);
        for (int r = 9; r >= 0; r--) begin
            s = subb(shift(s, -1), 1'b1) ^ round_key(k, r);
            if (r > 0) s = mixcols(s, 32'h0e0b0d09);
        end
        return s;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s;
        s = p ^ round_key(k, 0);
        for (int r = 1; r <= 10; r++) begin
            s = shift(subb(s, 1'b0), 1);
            if (r < 10) s = mixcols(s, 32'h02030101);
            s = s ^ round_key(k, r);
        end
        return s;
    endfunction

    // ---------------- job timing / cache model ----------------
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_cv   = 1'b0;
    bit           m_miss = 1'b0;
    int           m_since = 0;
    logic [127:0] m_ck   = '0;
    logic [127:0] m_key  = '0;
    logic [127:0] m_exp  = '0;
    logic [127:0] m_dout = '0;

    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) hs++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cv   = 1'b0;
            m_dout = '0;
        end else if (m_done) begin
            if (bus.out_ready) m_done = 1'b0;
        end else if (m_busy) begin
            m_since++;
            if (m_miss && m_since == 10) begin
                m_cv = 1'b1;
                m_ck = m_key;
            end
            if (m_since == (m_miss ? 21 : 11)) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_dout = m_exp;
            end
        end else if (bus.in_valid) begin
            m_miss  = !(m_cv && bus.key == m_ck);
            m_key   = bus.key;
            m_exp   = decrypt(bus.din, bus.key);
            m_since = 0;
            m_busy  = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        check128("in_ready", bus.in_ready, !(m_busy || m_done));
        check128("out_valid", bus.out_valid, m_done);
        check128("dout", bus.dout, m_dout);
    end

    // ---------------- driver ----------------
    task automatic run_job(input logic [127:0] k, input logic [127:0] c, input logic [127:0] pt,
                           input int exp_lat, input int hold, input string tag);
        int lat;
        int guard;
        int hs0;
        hs0 = hs;
        @(negedge clk);
        bus.key      = k;
        bus.din      = c;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check128({tag, "_accept"}, bus.in_ready, 1'b1);
        bus.out_ready = (hold == 0);
        @(negedge clk);
        // Inputs change after capture and must be ignored.
        bus.in_valid = 1'b0;
        bus.din      = {$urandom, $urandom, $urandom, $urandom};
        bus.key      = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (exp_lat > 0) check128({tag, "_latency"}, lat, exp_lat);
        check128({tag, "_pt"}, bus.dout, pt);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.din      = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check128({tag, "_hold_valid"}, bus.out_valid, 1'b1);
            check128({tag, "_hold_pt"}, bus.dout, pt);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check128({tag, "_handshakes"}, hs, hs0 + 1);
        check128({tag, "_ready_after"}, bus.in_ready, 1'b1);
        jobs++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        logic [127:0] k, p, c;
        logic [127:0] pool [3];
        int hs0;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.key       = '0;
        bus.out_ready = 1'b1;
        build_tables();

        // Pin the model to published values.
        check128("model_sbox_00", sb[0], 8'h63);
        check128("model_sbox_53", sb[8'h53], 8'hed);
        check128("model_isbox_00", isb[0], 8'h52);
        check128("model_dec_c1", decrypt(CtC1, KeyC1), PtC1);
        check128("model_enc_b", encrypt(PtB, KeyB), CtB);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check128("reset_in_ready", bus.in_ready, 1'b1);
        check128("reset_out_valid", bus.out_valid, 1'b0);
        check128("reset_dout", bus.dout, 128'h0);

        run_job(KeyC1, CtC1, PtC1, 21, 0, "c1");
        run_job(KeyB, CtB, PtB, 21, 0, "b_miss");
        run_job(KeyB, CtB, PtB, 11, 0, "b_hit");
        run_job(KeyC1, CtC1, PtC1, 21, 0, "alt_c1");
        run_job(KeyB, CtB, PtB, 21, 0, "alt_b");
        run_job(KeyC1, CtC1, PtC1, 21, 0, "alt_c1b");
        run_job(KeyC1, CtC1, PtC1, 11, 7, "bp");
        run_job(KeyB, CtB, PtB, 21, 0, "pre_rst");

        // Reset during the fifth KEYEXP cycle of a miss.
        hs0 = hs;
        @(negedge clk);
        bus.key      = KeyC1;
        bus.din      = CtC1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check128("abort_out_valid", bus.out_valid, 1'b0);
        end
        check128("abort_dout", bus.dout, 128'h0);
        check128("abort_handshakes", hs, hs0);
        run_job(KeyB, CtB, PtB, 21, 0, "rst_clears_cache");
        run_job(KeyC1, CtC1, PtC1, 21, 0, "after_rst");

        // Round trip through the encryption model.
        k = 128'h00112233445566778899aabbccddeeff;
        p = 128'h0123456789abcdef0123456789abcdef;
        run_job(k, encrypt(p, k), p, 21, 0, "rt0");
        for (int i = 0; i < 3; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            run_job(k, encrypt(p, k), p, 21, 0, $sformatf("rt%0d", i + 1));
        end

        // Random jobs over a small key pool so hits and misses interleave.
        for (int i = 0; i < 3; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 25; i++) begin
            k = pool[$urandom_range(0, 2)];
            c = {$urandom, $urandom, $urandom, $urandom};
            run_job(k, c, decrypt(c, k), 0, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        check128("total_handshakes", hs, jobs);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_dec.md
Name: aes_dec

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 decryption). It is the receive-side counterpart of the existing aes encryption core.
- Accepts a 128-bit ciphertext and key over a valid/ready handshake and returns the plaintext over a valid/ready handshake.
- Runs one round per clock. Round keys are derived on the fly: a forward key expansion produces k10, then the reverse key schedule walks from k10 back to k0.
- Holds a one-entry cache of the last key's k10, so repeated decryptions under the same key skip the expansion phase.

Parameters:
- NR, 10, number of rounds (AES-128 only; any other value is unsupported).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  din/key valid.
- in_ready  output  1  block can accept a new job.
- din  input  128  ciphertext, byte 0 = din[127:120].
- key  input  128  cipher key, same byte order as din.
- out_valid  output  1  dout holds the plaintext.
- out_ready  input  1  consumer accepts dout.
- dout  output  128  plaintext.

Behaviour:
- Reset (one clk edge with rst_n=0): FSM goes to IDLE; out_valid=0; dout=0; cache_valid=0; internal state, round counter and key registers cleared; in_ready=1 from the first cycle after reset.
- in_ready = (fsm==IDLE), combinational. Accept edge = rising clk with in_valid&in_ready. At the accept edge, din and key are captured; later changes on din/key are ignored.
- FSM states:
  - IDLE: on accept, go to KEYEXP, or to INIT on a cache hit (cache_valid && key==cache_key).
  - KEYEXP: 10 cycles. The working key reg starts at the captured key and becomes k_i at the i-th edge, with rcon 01,02,04,08,10,20,40,80,1b,36. On the 10th edge, load k10 into cache_k10, set cache_key=captured key, set cache_valid=1, go to INIT.
  - INIT: 1 cycle. state <= ct ^ k10; working key <= k10; rnd <= 9; go to ROUND.
  - ROUND: 10 cycles, rnd = 9 down to 0.
    - Compute k_rnd from the working key (k_{rnd+1}) via the reverse schedule: with words a0..a3 of k_{rnd+1}, b3=a3^a2, b2=a2^a1, b1=a1^a0, b0=a0^SubWord(RotWord(b3))^rcon[rnd+1].
    - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k_rnd), with InvMixColumns omitted when rnd==0.
    - On rnd==0: dout <= result, out_valid <= 1, go to DONE.
  - DONE: dout and out_valid held stable. At the edge where out_ready=1, out_valid <= 0 and go to IDLE. dout keeps its value until the next job completes.
- Latency (accept edge to the edge that sets out_valid): 21 clocks on a cache miss, 11 on a cache hit. With out_ready held high, the next accept is possible 2 edges after out_valid rises. No job overlap.
- out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored (no capture).
- rst_n=0 mid-job (any state) aborts the job: no out_valid pulse, cache invalidated, dout=0.
- The cache is updated only by a fully completed KEYEXP. A reset during KEYEXP leaves cache_valid=0.
- Both S-box (used by the reverse key schedule) and inverse S-box are combinational ROMs.
- All state is registered on the rising clk edge. There are no combinational paths from inputs to outputs other than in_ready (which is a function of FSM state only).

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, din=69c4e0d86a7b0430d8cdb78070b4c55a -> dout=00112233445566778899aabbccddeeff; out_valid rises exactly 21 clocks after accept.
- FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, din=3925841d02dc09fbdc118597196a0b32 -> dout=3243f6a8885a308d313198a2e0370734 (miss, 21 clocks). Then repeat the same key with din=3925…0b32 again -> same dout in 11 clocks (hit).
- Key alternation C.1 -> B -> C.1 -> every job is a miss (21 clocks); all dout values correct; in_ready=0 throughout each job.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid -> dout/out_valid stable and in_ready=0 with in_valid=1 pulsed; on release, exactly one handshake and in_ready=1 on the next cycle.
- Reset mid-job: assert rst_n=0 for 1 edge at cycle 5 of KEYEXP -> out_valid never rises, dout=0. Then resubmit C.1 with the same key -> 21-clock latency (cache cleared), correct plaintext.
- Round trip with aes: drive key=00112233445566778899aabbccddeeff and din=0123456789abcdef0123456789abcdef into aes, feed its dout into aes_dec with the same key -> aes_dec dout=0123456789abcdef0123456789abcdef; repeat for 3 random key/plaintext pairs.
